// File: rtl/fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_ctrl: fetch-stage sequencer (PC enable/select, IF/ID control, imem)  |
// | Optional FETCH_PERF_EN adds stall/redirect performance counters.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fetch_ctrl #(
  parameter int MAX_WAIT  = 15,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        br_taken,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        pipe_we,
  output logic        pipe_flush,
  output logic        fault,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam logic [CNT_W-1:0] C_FLUSH_LOAD = CNT_W'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0] C_WAIT_LAST  = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_RUN      = 3'd1,
    S_WAIT_MEM = 3'd2,
    S_FLUSH    = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             redir_pend, redir_pend_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_INIT;
      cnt        <= '0;
      redir_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      redir_pend <= redir_pend_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    redir_pend_nxt = redir_pend;
    imem_req       = 1'b0;
    pc_we          = 1'b0;
    pc_sel         = 1'b0;
    pipe_we        = 1'b0;
    pipe_flush     = 1'b0;
    fault          = 1'b0;
    case (state)
      S_INIT: begin
        pipe_flush     = 1'b1;
        cnt_nxt        = '0;
        redir_pend_nxt = 1'b0;
        state_nxt      = S_RUN;
      end
      S_RUN, S_WAIT_MEM: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          cnt_nxt = '0;
          if (br_taken || redir_pend) begin
            // Target is loaded on this edge; the fetched word is wrong-path.
            pc_sel         = 1'b1;
            pc_we          = 1'b1;
            pipe_flush     = 1'b1;
            redir_pend_nxt = 1'b0;
            cnt_nxt        = C_FLUSH_LOAD;
            state_nxt      = S_FLUSH;
          end else if (stall_in) begin
            state_nxt = S_RUN;
          end else begin
            pc_we     = 1'b1;
            pipe_we   = 1'b1;
            state_nxt = S_RUN;
          end
        end else begin
          if (br_taken) redir_pend_nxt = 1'b1;
          if (cnt == C_WAIT_LAST) begin
            state_nxt = S_FAULT;
          end else begin
            cnt_nxt   = cnt + C_CNT_ONE;
            state_nxt = S_WAIT_MEM;
          end
        end
      end
      S_FLUSH: begin
        pipe_flush = 1'b1;
        if (cnt == '0) state_nxt = S_RUN;
        else           cnt_nxt   = cnt - C_CNT_ONE;
      end
      S_FAULT: begin
        fault      = 1'b1;
        pipe_flush = 1'b1;
      end
      default: state_nxt = S_INIT;
    endcase
  end

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        stall_inc;

  assign stall_inc = ((state == S_RUN) || (state == S_WAIT_MEM)) && !pc_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      // pc_sel is asserted only on the redirect cycle.
      if (pc_sel && (flush_cnt_q != '1))    flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule
`default_nettype wire
